// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding and baud divider helper
package uart_pkg;
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t IDLE  = 2'd0;
  localparam rx_state_t START = 2'd1;
  localparam rx_state_t DATA  = 2'd2;
  localparam rx_state_t STOP  = 2'd3;
  localparam int OSR = 16;
  localparam logic [3:0] SMP_A = 4'd7;
  localparam logic [3:0] SMP_B = 4'd8;
  localparam logic [3:0] SMP_C = 4'd9;
  function automatic int calc_div(input longint clk_freq, input longint baud_rate);
    return int'((clk_freq + 8 * baud_rate) / (OSR * baud_rate));
  endfunction
endpackage

// File: rtl/uart_rx_sync_fifo.sv
// sync_fifo: show-ahead FIFO with wrap-bit pointers; head reads zero while empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= (pop && !empty) ? rd_ptr + 1'b1 : rd_ptr;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 16x oversampled majority voting, error pulses and an output FIFO
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RXD,
  output logic [7:0] DOUT,
  output logic       DOUT_VLD,
  input  logic       DOUT_RDY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int DW = $clog2(DIV + 1);
  localparam logic [3:0] SMP_END = 4'(OSR - 1);
  logic [1:0] rxd_q, vote;
  logic [DW-1:0] div_cnt;
  logic [3:0] smp, smp_nxt;
  logic [2:0] idx;
  logic [7:0] shreg;
  rx_state_t state;
  logic rxd_s, tick, start, maj, bit_q, brk, stop_done, stop_ok;
  logic full, empty, pop, push, overrun, fe_q, ov_q;
  always_comb begin
    rxd_s = rxd_q[1];
    tick = div_cnt == DW'(DIV - 1);
    smp_nxt = smp + 4'd1;
    start = state == IDLE && !rxd_s && !brk;
    maj = (vote[0] & vote[1]) | (rxd_s & (vote[0] | vote[1]));
    stop_done = state == STOP && tick && smp_nxt == SMP_C;
    stop_ok = stop_done && maj;
    pop = !empty && DOUT_RDY;
    push = stop_ok && (!full || pop);
    overrun = stop_ok && full && !pop;
  end
  assign DOUT_VLD = !empty;
  assign FRAME_ERR = fe_q;
  assign OVERRUN = ov_q;
  assign BUSY = state != IDLE;
  always_ff @(posedge CLK) begin
    if (RST) begin
      rxd_q <= 2'b11;
      div_cnt <= '0;
      smp <= '0;
      vote <= '0;
      bit_q <= 1'b0;
      brk <= 1'b0;
      idx <= '0;
      shreg <= '0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
      state <= IDLE;
    end else begin
      rxd_q <= {rxd_q[0], UART_RXD};
      div_cnt <= (start || tick) ? '0 : div_cnt + 1'b1;
      smp <= start ? '0 : tick ? smp_nxt : smp;
      fe_q <= stop_done && !maj;
      ov_q <= overrun;
      if (tick && smp_nxt == SMP_A) vote[0] <= rxd_s;
      if (tick && smp_nxt == SMP_B) vote[1] <= rxd_s;
      if (tick && smp_nxt == SMP_C) bit_q <= maj;
      // a low stop bit may be a break: hold off new starts until the line is seen high
      if (stop_done && !maj) brk <= 1'b1;
      else if (tick && rxd_s) brk <= 1'b0;
      case (state)
        IDLE: if (start) state <= START;
        START: if (tick && smp_nxt == SMP_END) begin
          state <= bit_q ? IDLE : DATA;
          idx <= '0;
        end
        DATA: if (tick && smp_nxt == SMP_END) begin
          shreg[idx] <= bit_q;
          idx <= idx + 1'b1;
          if (idx == 3'd7) state <= STOP;
        end
        STOP: if (stop_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push(push),
    .din(shreg),
    .pop(pop),
    .full(full),
    .empty(empty),
    .head(DOUT)
  );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames checked against a queue model of the receiver and its FIFO
module tb_uart_rx;
  localparam int BAUD = 115200;
  localparam int DIV = 4;
  localparam int CLKF = 16 * BAUD * DIV;
  localparam int BIT = CLKF / BAUD;
  localparam int DEPTH = 16;
  logic CLK = 0, RST = 1, UART_RXD = 1, DOUT_RDY = 0;
  logic [7:0] DOUT;
  logic DOUT_VLD, FRAME_ERR, OVERRUN, BUSY;
  int n_chk = 0, n_err = 0;
  int fe_cnt = 0, ov_cnt = 0, fe_exp = 0, ov_exp = 0, spur = 0, both = 0, wide = 0;
  logic [7:0] exp_q[$];
  uart_rx #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .UART_RXD(UART_RXD),
    .DOUT(DOUT),
    .DOUT_VLD(DOUT_VLD),
    .DOUT_RDY(DOUT_RDY),
    .FRAME_ERR(FRAME_ERR),
    .OVERRUN(OVERRUN),
    .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // model: a good frame enters the FIFO unless it already holds DEPTH bytes
  task automatic send(input logic [7:0] d, input logic stop, input int gbit);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    if (!stop) fe_exp++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else ov_exp++;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < BIT; c++) begin
        @(posedge CLK);
        #2;
        UART_RXD = (b == gbit && c >= BIT/2 - DIV/2 && c < BIT/2 + DIV/2) ? ~f[b] : f[b];
      end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
      UART_RXD = 1'b1;
    end
  endtask
  initial begin
    logic fe_prev, ov_prev;
    fe_prev = 0;
    ov_prev = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (DOUT_VLD && DOUT_RDY) begin
          if (exp_q.size() == 0) spur++;
          else check("dout", DOUT, exp_q.pop_front());
        end
        if (FRAME_ERR) fe_cnt++;
        if (OVERRUN) ov_cnt++;
        if (FRAME_ERR && OVERRUN) both++;
        if ((FRAME_ERR && fe_prev) || (OVERRUN && ov_prev)) wide++;
      end
      fe_prev = FRAME_ERR;
      ov_prev = OVERRUN;
    end
  end
  initial begin
    logic [7:0] d;
    logic good;
    int g;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("rst_vld", DOUT_VLD, 0);
    check("rst_dout", DOUT, 0);
    check("rst_fe", FRAME_ERR, 0);
    check("rst_ov", OVERRUN, 0);
    check("rst_busy", BUSY, 0);
    @(posedge CLK);
    #2;
    RST = 0;
    DOUT_RDY = 1;
    idle(BIT);
    fork
      send(8'h55, 1, -1);
      begin
        repeat (5 * BIT) @(posedge CLK);
        @(negedge CLK);
        check("busy_mid", BUSY, 1);
        repeat (9 * BIT + BIT/2 + DIV + 5 - 5 * BIT) @(posedge CLK);
        @(negedge CLK);
        check("busy_end", BUSY, 0);
      end
    join
    idle(BIT);
    check("single_q", exp_q.size(), 0);
    DOUT_RDY = 0;
    send(8'h1A, 1, -1);
    send(8'h00, 1, -1);
    send(8'hFF, 1, -1);
    idle(BIT);
    @(negedge CLK);
    check("b2b_vld", DOUT_VLD, 1);
    check("b2b_head", DOUT, 8'h1A);
    @(posedge CLK);
    #2;
    DOUT_RDY = 1;
    repeat (3) @(posedge CLK);
    #2;
    DOUT_RDY = 0;
    @(negedge CLK);
    check("b2b_empty", DOUT_VLD, 0);
    check("b2b_q", exp_q.size(), 0);
    @(posedge CLK);
    #2;
    DOUT_RDY = 1;
    send(8'hA5, 0, -1);
    idle(2 * BIT);
    send(8'h3C, 1, -1);
    idle(BIT);
    check("fe_cnt", fe_cnt, fe_exp);
    check("fe_q", exp_q.size(), 0);
    repeat (4 * DIV) begin
      @(posedge CLK);
      #2;
      UART_RXD = 1'b0;
    end
    idle(2 * BIT);
    @(negedge CLK);
    check("glitch_busy", BUSY, 0);
    check("glitch_fe", fe_cnt, fe_exp);
    send(8'h81, 1, 4);
    idle(BIT);
    check("glitch_q", exp_q.size(), 0);
    DOUT_RDY = 0;
    for (int i = 0; i <= DEPTH; i++) send(8'(i), 1, -1);
    idle(BIT);
    @(negedge CLK);
    check("ov_cnt", ov_cnt, ov_exp);
    check("ov_vld", DOUT_VLD, 1);
    @(posedge CLK);
    #2;
    DOUT_RDY = 1;
    idle(2 * DEPTH);
    @(negedge CLK);
    check("ov_q", exp_q.size(), 0);
    check("ov_drained", DOUT_VLD, 0);
    @(posedge CLK);
    #2;
    DOUT_RDY = 0;
    fork
      send(8'hF0, 1, -1);
      begin
        repeat (5 * BIT + BIT/2) @(posedge CLK);
        #2;
        RST = 1;
        @(posedge CLK);
        #2;
        RST = 0;
        exp_q.delete();
      end
    join
    idle(BIT);
    @(negedge CLK);
    check("rstmid_vld", DOUT_VLD, 0);
    check("rstmid_busy", BUSY, 0);
    @(posedge CLK);
    #2;
    DOUT_RDY = 1;
    send(8'h42, 1, -1);
    idle(BIT);
    check("rstmid_q", exp_q.size(), 0);
    for (int i = 0; i < 30; i++) begin
      d = 8'($urandom);
      good = $urandom_range(7, 0) != 0;
      g = ($urandom_range(1, 0) != 0) ? int'($urandom_range(9, 0)) : -1;
      send(d, good, g);
      idle(good ? int'($urandom_range(BIT, 0)) : BIT + int'($urandom_range(BIT, 0)));
    end
    idle(2 * BIT);
    check("rnd_q", exp_q.size(), 0);
    check("rnd_fe", fe_cnt, fe_exp);
    check("rnd_ov", ov_cnt, ov_exp);
    check("spurious", spur, 0);
    check("pulse_both", both, 0);
    check("pulse_wide", wide, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
